ram_port_b_arbiter: RTL and testbench

- Shares port B of the dual-port instruction/data RAM between two requesters: the CPU data port (load/store) and a debug/loader port that writes program images or reads memory for display.
- CPU has fixed priority. A starvation counter guarantees the debug port a grant within MAX_WAIT cycles.
- Handles the RAM's one-cycle synchronous read latency and returns read data to the requester that issued the read.
- Sits between the cpu data interface, the debug/loader interface and the address_b/data_b/wren_b/q_b pins of the RAM.

---
 rtl/ram_port_b_arbiter_pkg.sv | 15 +
 rtl/ram_port_b_arbiter_if.sv | 28 ++
 rtl/ram_port_b_arbiter.sv | 108 ++++++++++
 tb/tb_ram_port_b_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_b_arbiter_pkg.sv
// Shared definitions for the RAM port-B arbiter and its neighbours.
//   RAM_ADDR_W / RAM_DATA_W : geometry of the instruction/data RAM
//   rd_owner_e              : which requester owns the read data arriving next cycle
package ram_port_b_arbiter_pkg;

  localparam int RAM_ADDR_W = 11;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/ram_port_b_arbiter_if.sv
// Request/response bundle for one requester of RAM port B.
//   req    : access request, held with we/addr/wdata stable until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address
//   wdata  : write data
//   gnt    : access performed this cycle
//   rvalid : read data valid (one cycle after a read grant)
//   rdata  : read data, zero while rvalid is low
// master = requester side, slave = arbiter side.
interface ram_port_b_arbiter_if
  import ram_port_b_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/ram_port_b_arbiter.sv
// Arbiter sharing port B of the instruction/data RAM between the CPU data
// port (fixed priority) and the debug/loader port (starvation-protected).
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   cpu_if         : CPU requester bundle (slave side)
//   dbg_if         : debug/loader requester bundle (slave side)
//   ram_wren_o     : RAM wren_b
//   ram_addr_o     : RAM address_b
//   ram_din_o      : RAM data_b
//   ram_q_i        : RAM q_b, valid one cycle after the address
//   conflict_cnt_o : count of cycles with both requests high (wraps)
module ram_port_b_arbiter
  import ram_port_b_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_port_b_arbiter_if.slave  cpu_if,
  ram_port_b_arbiter_if.slave  dbg_if,
  output logic                 ram_wren_o,
  output logic [ADDR_W-1:0]    ram_addr_o,
  output logic [DATA_W-1:0]    ram_din_o,
  input  logic [DATA_W-1:0]    ram_q_i,
  output logic [CNT_W-1:0]     conflict_cnt_o
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  rd_owner_e         rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic force_dbg;
  logic cpu_gnt;
  logic dbg_gnt;

  // Grant decision: a debug request that has waited MAX_WAIT cycles beats
  // the CPU for one cycle; otherwise the CPU wins. Grants are held off
  // during reset so no RAM write can slip through.
  always_comb begin
    force_dbg = dbg_if.req && (wait_cnt_q == WAIT_MAX);
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    if (rst_n) begin
      if (force_dbg)       dbg_gnt = 1'b1;
      else if (cpu_if.req) cpu_gnt = 1'b1;
      else if (dbg_if.req) dbg_gnt = 1'b1;
    end
  end

  // RAM pin mux: idle cycles drive all zeros.
  always_comb begin
    ram_wren_o = 1'b0;
    ram_addr_o = '0;
    ram_din_o  = '0;
    if (cpu_gnt) begin
      ram_wren_o = cpu_if.we;
      ram_addr_o = cpu_if.addr;
      ram_din_o  = cpu_if.wdata;
    end else if (dbg_gnt) begin
      ram_wren_o = dbg_if.we;
      ram_addr_o = dbg_if.addr;
      ram_din_o  = dbg_if.wdata;
    end
  end

  // Next-state logic for starvation counter, read owner and conflict counter.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_if.req || dbg_gnt)    wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    // The RAM returns data one cycle after the address, so remember who
    // issued this cycle's read.
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_if.we)      rd_owner_d = OWN_CPU;
    else if (dbg_gnt && !dbg_if.we) rd_owner_d = OWN_DBG;

    conflict_cnt_d = conflict_cnt_q;
    if (cpu_if.req && dbg_if.req) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q     <= '0;
      rd_owner_q     <= OWN_NONE;
      conflict_cnt_q <= '0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      rd_owner_q     <= rd_owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign cpu_if.gnt     = cpu_gnt;
  assign dbg_if.gnt     = dbg_gnt;
  assign cpu_if.rvalid  = (rd_owner_q == OWN_CPU);
  assign dbg_if.rvalid  = (rd_owner_q == OWN_DBG);
  assign cpu_if.rdata   = (rd_owner_q == OWN_CPU) ? ram_q_i : '0;
  assign dbg_if.rdata   = (rd_owner_q == OWN_DBG) ? ram_q_i : '0;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Directed bench for ram_port_b_arbiter with a behavioural synchronous RAM.
module tb_ram_port_b_arbiter;
  import ram_port_b_arbiter_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_port_b_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_bus ();
  ram_port_b_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_bus ();

  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_q;
  logic [CW-1:0] conflict_cnt;

  // Synchronous RAM: write at the edge, read data registered one cycle later.
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  ram_port_b_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .CNT_W(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_if         (cpu_bus),
    .dbg_if         (dbg_bus),
    .ram_wren_o     (ram_wren),
    .ram_addr_o     (ram_addr),
    .ram_din_o      (ram_din),
    .ram_q_i        (ram_q),
    .conflict_cnt_o (conflict_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_conf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_bus.req = req; cpu_bus.we = we; cpu_bus.addr = a; cpu_bus.wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_bus.req = req; dbg_bus.we = we; dbg_bus.addr = a; dbg_bus.wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests high: grants must stay low.
    rst_n = 1'b0;
    set_cpu(1'b1, 1'b1, 11'h001, 32'h1111_1111);
    set_dbg(1'b1, 1'b1, 11'h002, 32'h2222_2222);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_gnt",  32'(cpu_bus.gnt), 32'd0);
    chk("rst_dbg_gnt",  32'(dbg_bus.gnt), 32'd0);
    chk("rst_wren",     32'(ram_wren), 32'd0);
    chk("rst_addr",     32'(ram_addr), 32'd0);
    chk("rst_din",      ram_din, 32'd0);
    chk("rst_cpu_rv",   32'(cpu_bus.rvalid), 32'd0);
    chk("rst_dbg_rv",   32'(dbg_bus.rvalid), 32'd0);
    chk("rst_cpu_rd",   cpu_bus.rdata, 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    set_dbg(1'b0, 1'b0, 11'h000, 32'h0);
    rst_n = 1'b1;

    // CPU-only write then read-back.
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 11'h005, 32'hDEAD_BEEF);
    #1;
    chk("cw_gnt",  32'(cpu_bus.gnt), 32'd1);
    chk("cw_dgnt", 32'(dbg_bus.gnt), 32'd0);
    chk("cw_wren", 32'(ram_wren), 32'd1);
    chk("cw_addr", 32'(ram_addr), 32'h005);
    chk("cw_din",  ram_din, 32'hDEAD_BEEF);
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 11'h005, 32'h0);
    #1;
    chk("cr_gnt",  32'(cpu_bus.gnt), 32'd1);
    chk("cr_wren", 32'(ram_wren), 32'd0);
    chk("cr_addr", 32'(ram_addr), 32'h005);
    chk("cr_rv_after_write", 32'(cpu_bus.rvalid), 32'd0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    #1;
    chk("cr_rvalid", 32'(cpu_bus.rvalid), 32'd1);
    chk("cr_rdata",  cpu_bus.rdata, 32'hDEAD_BEEF);
    chk("cr_dbg_rv", 32'(dbg_bus.rvalid), 32'd0);
    chk("cr_dbg_rd", dbg_bus.rdata, 32'd0);
    @(negedge clk);
    #1;
    chk("cr_rv_pulse", 32'(cpu_bus.rvalid), 32'd0);

    // Contention: cpu x4, forced dbg, then cpu resumes.
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 11'h020, 32'h0);
    set_dbg(1'b1, 1'b0, 11'h021, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("ct_cpu_gnt", 32'(cpu_bus.gnt), 32'(i != 4));
      chk("ct_dbg_gnt", 32'(dbg_bus.gnt), 32'(i == 4));
      chk("ct_cpu_rv",  32'(cpu_bus.rvalid), 32'(i >= 1 && i <= 4));
      chk("ct_dbg_rv",  32'(dbg_bus.rvalid), 32'(i == 5));
      if (i == 5) chk("ct_conflict5", 32'(conflict_cnt), 32'd5);
      @(negedge clk);
    end
    set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    set_dbg(1'b0, 1'b0, 11'h000, 32'h0);
    exp_conf = 6;
    #1;
    chk("ct_cpu_rv_last", 32'(cpu_bus.rvalid), 32'd1);
    chk("ct_conflict6",   32'(conflict_cnt), 32'(exp_conf));

    // Debug path with CPU idle.
    @(negedge clk);
    set_dbg(1'b1, 1'b1, 11'h7FF, 32'h1234_5678);
    #1;
    chk("dw_gnt",  32'(dbg_bus.gnt), 32'd1);
    chk("dw_cgnt", 32'(cpu_bus.gnt), 32'd0);
    chk("dw_wren", 32'(ram_wren), 32'd1);
    chk("dw_addr", 32'(ram_addr), 32'h7FF);
    chk("dw_din",  ram_din, 32'h1234_5678);
    @(negedge clk);
    set_dbg(1'b1, 1'b0, 11'h7FF, 32'h0);
    #1;
    chk("dr_gnt",  32'(dbg_bus.gnt), 32'd1);
    chk("dr_wren", 32'(ram_wren), 32'd0);
    @(negedge clk);
    set_dbg(1'b0, 1'b0, 11'h000, 32'h0);
    #1;
    chk("dr_rvalid", 32'(dbg_bus.rvalid), 32'd1);
    chk("dr_rdata",  dbg_bus.rdata, 32'h1234_5678);
    chk("dr_cpu_rv", 32'(cpu_bus.rvalid), 32'd0);

    // Interleaved reads: preload, then cpu reads 0x010 until dbg is forced onto 0x011.
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 11'h010, 32'hA1A1_A1A1);
    #1;
    chk("il_pre_cpu", 32'(cpu_bus.gnt), 32'd1);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    set_dbg(1'b1, 1'b1, 11'h011, 32'hB2B2_B2B2);
    #1;
    chk("il_pre_dbg", 32'(dbg_bus.gnt), 32'd1);
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 11'h010, 32'h0);
    set_dbg(1'b1, 1'b0, 11'h011, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("il_cpu_gnt", 32'(cpu_bus.gnt), 32'(i != 4 && i <= 5));
      chk("il_dbg_gnt", 32'(dbg_bus.gnt), 32'(i == 4));
      chk("il_rv_excl", 32'(cpu_bus.rvalid && dbg_bus.rvalid), 32'd0);
      chk("il_cpu_rv",  32'(cpu_bus.rvalid), 32'((i >= 1 && i <= 4) || i == 6));
      chk("il_dbg_rv",  32'(dbg_bus.rvalid), 32'(i == 5));
      if ((i >= 1 && i <= 4) || i == 6) chk("il_cpu_rd", cpu_bus.rdata, 32'hA1A1_A1A1);
      if (i == 5) chk("il_dbg_rd", dbg_bus.rdata, 32'hB2B2_B2B2);
      @(negedge clk);
      if (i == 4) set_dbg(1'b0, 1'b0, 11'h000, 32'h0);
      if (i == 5) set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    end
    exp_conf = 11;
    #1;
    chk("il_conflict", 32'(conflict_cnt), 32'(exp_conf));

    // Reset asserted after a read grant, before the capturing edge.
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 11'h010, 32'h0);
    #1;
    chk("mr_gnt_pre", 32'(cpu_bus.gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_conf = 0;
    #1;
    chk("mr_cpu_gnt",  32'(cpu_bus.gnt), 32'd0);
    chk("mr_dbg_gnt",  32'(dbg_bus.gnt), 32'd0);
    chk("mr_wren",     32'(ram_wren), 32'd0);
    chk("mr_addr",     32'(ram_addr), 32'd0);
    chk("mr_conflict", 32'(conflict_cnt), 32'(exp_conf));
    @(posedge clk);
    #1;
    chk("mr_cpu_rv", 32'(cpu_bus.rvalid), 32'd0);
    chk("mr_cpu_rd", cpu_bus.rdata, 32'd0);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 11'h030, 32'hCAFE_F00D);
    set_dbg(1'b1, 1'b1, 11'h031, 32'h0000_0055);
    #1;
    chk("ar_cpu_gnt", 32'(cpu_bus.gnt), 32'd1);
    chk("ar_dbg_gnt", 32'(dbg_bus.gnt), 32'd0);
    chk("ar_addr",    32'(ram_addr), 32'h030);
    chk("ar_din",     ram_din, 32'hCAFE_F00D);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 11'h000, 32'h0);
    exp_conf = 1;
    #1;
    chk("ar_dbg_gnt2", 32'(dbg_bus.gnt), 32'd1);
    chk("ar_addr2",    32'(ram_addr), 32'h031);
    @(negedge clk);
    set_dbg(1'b0, 1'b0, 11'h000, 32'h0);
    #1;
    chk("ar_conflict", 32'(conflict_cnt), 32'(exp_conf));

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("id_wren",   32'(ram_wren), 32'd0);
      chk("id_addr",   32'(ram_addr), 32'd0);
      chk("id_gnts",   32'({cpu_bus.gnt, dbg_bus.gnt}), 32'd0);
      chk("id_rvalid", 32'({cpu_bus.rvalid, dbg_bus.rvalid}), 32'd0);
    end
    chk("id_conflict", 32'(conflict_cnt), 32'(exp_conf));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
